mem_writeback_unit: RTL and testbench

- Stage directly downstream of execute. It consumes the latched ALU result, store operand, destination register and instruction kind.
- It performs the data-memory access over a req/ack handshake of variable latency, then drives the register-file write port.
- It accepts one instruction at a time under a valid/ready handshake from execute and signals retirement to the control unit.

---
 rtl/mem_wb_pkg.sv | 42 ++++
 rtl/wb_result_sel.sv | 37 +++
 rtl/mem_writeback_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_writeback_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types for the memory/writeback stage.
//   state_e     : FSM state encoding (IDLE, ACCESS, WB, RETIRE)
//   kind_e      : instruction kind after priority resolution
//   kind_encode : resolves overlapping kind flags, priority st > ld > call > wb
package mem_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWb,
    StRetire
  } state_e;

  typedef enum logic [2:0] {
    KIND_NONE,
    KIND_ST,
    KIND_LD,
    KIND_CALL,
    KIND_WB
  } kind_e;

  // Register written with the return address by a call.
  localparam int unsigned RA_REG_DEFAULT = 15;

  function automatic kind_e kind_encode(input logic is_ld, input logic is_st,
                                        input logic is_call, input logic is_wb);
    kind_e kind;
    if (is_st) begin
      kind = KIND_ST;
    end else if (is_ld) begin
      kind = KIND_LD;
    end else if (is_call) begin
      kind = KIND_CALL;
    end else if (is_wb) begin
      kind = KIND_WB;
    end else begin
      kind = KIND_NONE;
    end
    return kind;
  endfunction

endpackage

// File: rtl/wb_result_sel.sv
// Register-file write address/data select for the writeback stage.
// Ports:
//   kind_i       : resolved instruction kind (mem_wb_pkg::kind_e encoding)
//   rd_i         : captured destination register
//   load_data_i  : word returned by the data memory
//   npc_i        : captured next PC (return address for calls)
//   alu_result_i : captured ALU result
//   dr_addr_o    : register-file write address
//   wr_data_o    : register-file write data
module wb_result_sel
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned RA_REG     = RA_REG_DEFAULT
) (
  input  logic [2:0]            kind_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [DATA_W-1:0]     load_data_i,
  input  logic [DATA_W-1:0]     npc_i,
  input  logic [DATA_W-1:0]     alu_result_i,
  output logic [REG_ADDR_W-1:0] dr_addr_o,
  output logic [DATA_W-1:0]     wr_data_o
);

  always_comb begin
    dr_addr_o = rd_i;
    wr_data_o = alu_result_i;
    if (kind_i == 3'(KIND_LD)) begin
      wr_data_o = load_data_i;
    end else if (kind_i == 3'(KIND_CALL)) begin
      dr_addr_o = REG_ADDR_W'(RA_REG);
      wr_data_o = npc_i;
    end
  end

endmodule

// File: rtl/mem_writeback_unit.sv
// Memory-access and register-writeback stage downstream of execute.
// Accepts one instruction at a time (inValid/inReady), performs an optional data-memory access
// over a variable-latency req/ack handshake, writes the register file for one cycle and pulses
// done on retirement. All outputs are registered.
// Ports:
//   clk, rstN                 : clock, synchronous active-low reset
//   inValid/inReady           : instruction handshake from execute
//   aluResult, storeData, npc : instruction operands (captured on accept)
//   rd, isLd/isSt/isCall/isWb : destination register and kind flags
//   dmemReq/We/Addr/Wdata     : data-memory request, held stable until ack
//   dmemRdata, dmemAck        : data-memory response
//   wrRegister/drAddr/writeRegData : register-file write port
//   done                      : one-cycle retire pulse
//   memErr                    : access aborted by timeout
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS after MEM_TIMEOUT_CYCLES cycles
// without ack; otherwise ACCESS waits indefinitely and memErr is tied low.
module mem_writeback_unit
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W             = 32,
  parameter int unsigned REG_ADDR_W         = 4,
  parameter int unsigned RA_REG             = RA_REG_DEFAULT,
  parameter int unsigned MEM_TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_W-1:0]     aluResult,
  input  logic [DATA_W-1:0]     storeData,
  input  logic [DATA_W-1:0]     npc,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  isLd,
  input  logic                  isSt,
  input  logic                  isCall,
  input  logic                  isWb,
  output logic                  dmemReq,
  output logic                  dmemWe,
  output logic [DATA_W-1:0]     dmemAddr,
  output logic [DATA_W-1:0]     dmemWdata,
  input  logic [DATA_W-1:0]     dmemRdata,
  input  logic                  dmemAck,
  output logic                  wrRegister,
  output logic [REG_ADDR_W-1:0] drAddr,
  output logic [DATA_W-1:0]     writeRegData,
  output logic                  done,
  output logic                  memErr
);

  state_e                state_q, state_d;
  kind_e                 kind_q, kind_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     store_q, store_d;
  logic [DATA_W-1:0]     npc_q, npc_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     load_data_q, load_data_d;

  logic                  in_ready_q, in_ready_d;
  logic                  dmem_req_q, dmem_req_d;
  logic                  dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0]     dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]     dmem_wdata_q, dmem_wdata_d;
  logic                  wr_register_q, wr_register_d;
  logic [REG_ADDR_W-1:0] dr_addr_q, dr_addr_d;
  logic [DATA_W-1:0]     write_reg_data_q, write_reg_data_d;
  logic                  done_q, done_d;

  logic [REG_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_data;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (MEM_TIMEOUT_CYCLES == 0);
`endif

  // Next-state and capture logic.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    alu_d       = alu_q;
    store_d     = store_q;
    npc_d       = npc_q;
    rd_d        = rd_q;
    load_data_d = load_data_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    mem_err_d   = mem_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (inValid && in_ready_q) begin
          kind_d  = kind_encode(isLd, isSt, isCall, isWb);
          alu_d   = aluResult;
          store_d = storeData;
          npc_d   = npc;
          rd_d    = rd;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
          mem_err_d = 1'b0;
`endif
          unique case (kind_d)
            KIND_ST, KIND_LD:  state_d = StAccess;
            KIND_CALL, KIND_WB: state_d = StWb;
            default:           state_d = StRetire;
          endcase
        end
      end
      StAccess: begin
        // Ack takes precedence over a timeout expiring on the same edge.
        if (dmemAck) begin
          if (kind_q == KIND_LD) begin
            load_data_d = dmemRdata;
            state_d     = StWb;
          end else begin
            state_d = StRetire;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CntW'(MEM_TIMEOUT_CYCLES - 1)) begin
          state_d   = StRetire;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StWb:     state_d = StRetire;
      StRetire: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  wb_result_sel #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .RA_REG     (RA_REG)
  ) u_wb_result_sel (
    .kind_i       (kind_d),
    .rd_i         (rd_d),
    .load_data_i  (load_data_d),
    .npc_i        (npc_d),
    .alu_result_i (alu_d),
    .dr_addr_o    (sel_addr),
    .wr_data_o    (sel_data)
  );

  // Outputs are decoded from the next state so they appear registered in that state.
  always_comb begin
    in_ready_d       = (state_d == StIdle);
    dmem_req_d       = (state_d == StAccess);
    dmem_we_d        = dmem_req_d && (kind_d == KIND_ST);
    dmem_addr_d      = dmem_req_d ? {alu_d[DATA_W-1:2], 2'b00} : '0;
    dmem_wdata_d     = dmem_req_d ? store_d : '0;
    wr_register_d    = (state_d == StWb);
    dr_addr_d        = wr_register_d ? sel_addr : '0;
    write_reg_data_d = wr_register_d ? sel_data : '0;
    done_d           = (state_d == StRetire);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q          <= StIdle;
      kind_q           <= KIND_NONE;
      alu_q            <= '0;
      store_q          <= '0;
      npc_q            <= '0;
      rd_q             <= '0;
      load_data_q      <= '0;
      in_ready_q       <= 1'b1;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_wdata_q     <= '0;
      wr_register_q    <= 1'b0;
      dr_addr_q        <= '0;
      write_reg_data_q <= '0;
      done_q           <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q            <= '0;
      mem_err_q        <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      kind_q           <= kind_d;
      alu_q            <= alu_d;
      store_q          <= store_d;
      npc_q            <= npc_d;
      rd_q             <= rd_d;
      load_data_q      <= load_data_d;
      in_ready_q       <= in_ready_d;
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wdata_q     <= dmem_wdata_d;
      wr_register_q    <= wr_register_d;
      dr_addr_q        <= dr_addr_d;
      write_reg_data_q <= write_reg_data_d;
      done_q           <= done_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q            <= cnt_d;
      mem_err_q        <= mem_err_d;
`endif
    end
  end

  assign inReady      = in_ready_q;
  assign dmemReq      = dmem_req_q;
  assign dmemWe       = dmem_we_q;
  assign dmemAddr     = dmem_addr_q;
  assign dmemWdata    = dmem_wdata_q;
  assign wrRegister   = wr_register_q;
  assign drAddr       = dr_addr_q;
  assign writeRegData = write_reg_data_q;
  assign done         = done_q;
`ifdef MEM_TIMEOUT_EN
  assign memErr       = mem_err_q;
`else
  assign memErr       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_writeback_unit.sv
// Self-checking bench for mem_writeback_unit. Each transaction's expected cycle-by-cycle
// timeline (ACCESS cycles, optional WB, RETIRE, back to IDLE) is built from the stage's
// latency and kind-priority rules and compared against the DUT outputs.
module tb_mem_writeback_unit;

  localparam int DW      = 32;
  localparam int AW      = 4;
  localparam int TIMEOUT = 4;
  localparam logic [AW-1:0] RA = 4'd15;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [DW-1:0] aluResult = '0;
  logic [DW-1:0] storeData = '0;
  logic [DW-1:0] npc = '0;
  logic [AW-1:0] rd = '0;
  logic          isLd = 1'b0, isSt = 1'b0, isCall = 1'b0, isWb = 1'b0;
  logic          dmemReq, dmemWe;
  logic [DW-1:0] dmemAddr, dmemWdata;
  logic [DW-1:0] dmemRdata = '0;
  logic          dmemAck = 1'b0;
  logic          wrRegister;
  logic [AW-1:0] drAddr;
  logic [DW-1:0] writeRegData;
  logic          done, memErr;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_writeback_unit #(
    .DATA_W             (DW),
    .REG_ADDR_W         (AW),
    .RA_REG             (15),
    .MEM_TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .inValid      (inValid),
    .inReady      (inReady),
    .aluResult    (aluResult),
    .storeData    (storeData),
    .npc          (npc),
    .rd           (rd),
    .isLd         (isLd),
    .isSt         (isSt),
    .isCall       (isCall),
    .isWb         (isWb),
    .dmemReq      (dmemReq),
    .dmemWe       (dmemWe),
    .dmemAddr     (dmemAddr),
    .dmemWdata    (dmemWdata),
    .dmemRdata    (dmemRdata),
    .dmemAck      (dmemAck),
    .wrRegister   (wrRegister),
    .drAddr       (drAddr),
    .writeRegData (writeRegData),
    .done         (done),
    .memErr       (memErr)
  );

  // Runs one instruction starting from an IDLE sample point and checks every cycle until the
  // stage is back in IDLE. ack_delay = number of ACCESS cycles up to and including the ack
  // cycle; 0 means no ack ever arrives.
  task automatic run_txn(input logic ld, input logic st, input logic call, input logic wb,
                         input int ack_delay, input logic [DW-1:0] alu,
                         input logic [DW-1:0] sd, input logic [DW-1:0] npc_v,
                         input logic [DW-1:0] rdata, input logic [AW-1:0] rd_v);
    int            acc, total;
    bit            is_mem, timed_out, has_wb;
    bit            in_acc, in_wb, in_ret, in_idle, exp_err;
    logic [DW-1:0] exp_data, exp_maddr;
    logic [AW-1:0] exp_raddr;
    is_mem    = ld || st;
    timed_out = is_mem && (ack_delay == 0);
    acc       = !is_mem ? 0 : (timed_out ? TIMEOUT : ack_delay);
    has_wb    = !st && (ld || call || wb) && !timed_out;
    exp_data  = ld ? rdata : (call ? npc_v : alu);
    exp_raddr = (!ld && call) ? RA : rd_v;
    exp_maddr = alu & ~32'h3;
    total     = acc + (has_wb ? 1 : 0) + 2;

    inValid = 1'b1; aluResult = alu; storeData = sd; npc = npc_v; rd = rd_v;
    isLd = ld; isSt = st; isCall = call; isWb = wb;
    @(posedge clk); #1;
    inValid = 1'b0;
    aluResult = $urandom; storeData = $urandom; npc = $urandom; rd = AW'($urandom);
    isLd = 1'($urandom); isSt = 1'($urandom); isCall = 1'($urandom); isWb = 1'($urandom);

    for (int c = 1; c <= total; c++) begin
      dmemAck   = 1'b0;
      dmemRdata = $urandom;
      in_acc  = (c <= acc);
      in_wb   = has_wb && (c == acc + 1);
      in_ret  = (c == total - 1);
      in_idle = (c == total);
      exp_err = timed_out && (c > acc);

      n_cmp++;
      if (inReady !== in_idle) begin
        n_fail++; $display("FAIL inReady cycle %0d: got %b want %b", c, inReady, in_idle);
      end
      n_cmp++;
      if (dmemReq !== in_acc) begin
        n_fail++; $display("FAIL dmemReq cycle %0d: got %b want %b", c, dmemReq, in_acc);
      end
      if (in_acc) begin
        n_cmp++;
        if (dmemWe !== st) begin
          n_fail++; $display("FAIL dmemWe cycle %0d: got %b want %b", c, dmemWe, st);
        end
        n_cmp++;
        if (dmemAddr !== exp_maddr) begin
          n_fail++;
          $display("FAIL dmemAddr cycle %0d: got %h want %h", c, dmemAddr, exp_maddr);
        end
        n_cmp++;
        if (dmemWdata !== sd) begin
          n_fail++; $display("FAIL dmemWdata cycle %0d: got %h want %h", c, dmemWdata, sd);
        end
      end
      n_cmp++;
      if (wrRegister !== in_wb) begin
        n_fail++; $display("FAIL wrRegister cycle %0d: got %b want %b", c, wrRegister, in_wb);
      end
      if (in_wb) begin
        n_cmp++;
        if (drAddr !== exp_raddr) begin
          n_fail++; $display("FAIL drAddr cycle %0d: got %h want %h", c, drAddr, exp_raddr);
        end
        n_cmp++;
        if (writeRegData !== exp_data) begin
          n_fail++;
          $display("FAIL writeRegData cycle %0d: got %h want %h", c, writeRegData, exp_data);
        end
      end
      n_cmp++;
      if (done !== in_ret) begin
        n_fail++; $display("FAIL done cycle %0d: got %b want %b", c, done, in_ret);
      end
      n_cmp++;
      if (memErr !== exp_err) begin
        n_fail++; $display("FAIL memErr cycle %0d: got %b want %b", c, memErr, exp_err);
      end

      if (in_acc && (c == ack_delay)) begin
        dmemAck   = 1'b1;
        dmemRdata = rdata;
      end
      if (c < total) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (inReady !== 1'b1) begin
      n_fail++; $display("FAIL reset_inReady: got %b want 1", inReady);
    end
    n_cmp++;
    if ({dmemReq, dmemWe, wrRegister, done, memErr} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {dmemReq, dmemWe, wrRegister, done, memErr});
    end
    n_cmp++;
    if ({dmemAddr, dmemWdata, drAddr, writeRegData} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h/%h/%h want 0", dmemAddr, dmemWdata, drAddr,
               writeRegData);
    end
    rstN = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (inReady !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_inReady: got %b want 1", inReady);
    end
  endtask

  task automatic test_alu();
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0000_002A, 32'h0, 32'h0, 32'h0, 4'd3);
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 3, 32'h0000_0013, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'd9);
  endtask

  task automatic test_load();
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h0000_0100, 32'h0, 32'h0, 32'h1234_5678, 4'd5);
  endtask

  task automatic test_call();
    run_txn(1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0000_0777, 32'h0, 32'h0000_0040, 32'h0, 4'd2);
  endtask

  task automatic test_no_writeback();
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 4'd6);
  endtask

  // Overlapping kind flags: ld+st acts as a store, ld+call as a load, call+wb as a call.
  task automatic test_priority();
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 2, 32'h0000_2003, 32'hCAFE_F00D, 32'h0, 32'h0, 4'd1);
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 2, 32'h0000_3001, 32'h0, 32'h0000_0080, 32'hA5A5_5A5A,
            4'd4);
    run_txn(1'b0, 1'b0, 1'b1, 1'b1, 0, 32'h0000_0011, 32'h0, 32'h0000_00C0, 32'h0, 4'd7);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b0, 1'b0, 1'b0, 1'b1, 0, $urandom, $urandom, $urandom, $urandom,
              AW'(i + 8));
    end
`ifndef MEM_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 20, 32'h0000_4446, 32'h0, 32'h0, 32'h0BAD_F00D, 4'd12);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(1, TIMEOUT)), $urandom, $urandom, $urandom, $urandom,
              AW'($urandom));
    end
  endtask

  task automatic test_reset_mid_access();
    inValid = 1'b1; isLd = 1'b1; isSt = 1'b0; isCall = 1'b0; isWb = 1'b0;
    aluResult = 32'h0000_0200; rd = 4'd7;
    @(posedge clk); #1;
    inValid = 1'b0; isLd = 1'b0;
    n_cmp++;
    if (dmemReq !== 1'b1) begin
      n_fail++; $display("FAIL midrst_req_before: got %b want 1", dmemReq);
    end
    @(posedge clk); #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (dmemReq !== 1'b0) begin
      n_fail++; $display("FAIL midrst_req_after: got %b want 0", dmemReq);
    end
    n_cmp++;
    if (inReady !== 1'b1) begin
      n_fail++; $display("FAIL midrst_inReady: got %b want 1", inReady);
    end
    rstN = 1'b1;
    dmemAck = 1'b1;
    dmemRdata = 32'hFFFF_0000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({wrRegister, done, dmemReq} !== 3'b000) begin
        n_fail++;
        $display("FAIL late_ack cycle %0d: got wr/done/req=%b want 000", c,
                 {wrRegister, done, dmemReq});
      end
      n_cmp++;
      if (inReady !== 1'b1) begin
        n_fail++; $display("FAIL late_ack_inReady cycle %0d: got %b want 1", c, inReady);
      end
    end
    dmemAck = 1'b0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0000_0300, 32'h0, 32'h0, 32'h0, 4'd3);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0000_0304, 32'h1111_2222, 32'h0, 32'h0, 4'd3);
    // Next capture clears the sticky error.
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0000_0009, 32'h0, 32'h0, 32'h0, 4'd8);
    // Ack on the same edge the limit is reached completes normally.
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, TIMEOUT, 32'h0000_0400, 32'h0, 32'h0, 32'h7777_8888,
            4'd10);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_call();
    test_no_writeback();
    test_priority();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
